time_set_ctrl: RTL and testbench

//  Timekeeper and set-mode controller for the hh:mm:ss clock datapath.

---
 rtl/time_ctrl_pkg.sv | 35 +++
 rtl/time_set_ctrl_if.sv | 29 ++
 rtl/time_set_ctrl_wrap_stepper.sv | 38 +++
 rtl/time_set_ctrl.sv | 98 +++++++++
 tb/tb_time_set_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/time_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_ctrl_pkg
//  Description : Shared state encoding, field codes and moduli for the
//                time_set_ctrl timekeeper.
//  Revision    : 1.0 - initial release
// ============================================================================
package time_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } tctl_state_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HR   = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_SEC  = 2'd3;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;

    function automatic logic [1:0] state_field(input tctl_state_t s);
        case (s)
            RUN:     return FLD_NONE;
            SET_HR:  return FLD_HR;
            SET_MIN: return FLD_MIN;
            default: return FLD_SEC;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl_if
//  Description : Button/tick inputs and time/display outputs of the
//                timekeeper, bundled for the controller and its driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface time_set_ctrl_if;
    logic       tick_1hz;
    logic       mode_btn;
    logic       up_btn;
    logic       down_btn;
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
    logic [1:0] edit_field;
    logic       day_pulse;

    modport master (
        output tick_1hz, mode_btn, up_btn, down_btn,
        input  hr, min, sec, edit_field, day_pulse
    );

    modport slave (
        input  tick_1hz, mode_btn, up_btn, down_btn,
        output hr, min, sec, edit_field, day_pulse
    );
endinterface
`default_nettype wire

// File: rtl/time_set_ctrl_wrap_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_stepper
//  Description : Combinational mod-MOD +/-1 stepper with wrap flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrap_stepper #(
    parameter int MOD = 60
) (
    input  wire logic [7:0] val,
    input  wire logic       inc,
    input  wire logic       dec,
    output logic      [7:0] nxt,
    output logic            wrap
);
    localparam logic [7:0] c_max = 8'(MOD - 1);

    always_comb begin
        nxt  = val;
        wrap = 1'b0;
        if (inc && !dec) begin
            if (val == c_max) begin
                nxt  = 8'd0;
                wrap = 1'b1;
            end else begin
                nxt  = val + 8'd1;
            end
        end else if (dec && !inc) begin
            if (val == 8'd0) begin
                nxt  = c_max;
                wrap = 1'b1;
            end else begin
                nxt  = val - 8'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl
//  Description : hh:mm:ss timekeeper with mode/up/down set-mode sequencer.
//                Optional macro TICK_IN_SET_EN keeps time running while
//                editing (an edit in the same cycle drops that tick).
//  Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int HOURS_MOD = 24
) (
    input wire logic        clk,
    input wire logic        rst,
    time_set_ctrl_if.slave  bus
);
    tctl_state_t r_state;
    tctl_state_t w_state_nxt;

    logic [7:0] r_hr, r_min, r_sec;
    logic       r_day;

    logic       w_edit, w_tick_go;
    logic       w_sec_inc, w_sec_dec, w_sec_wrap;
    logic       w_min_inc, w_min_dec, w_min_wrap;
    logic       w_hr_inc,  w_hr_dec,  w_hr_wrap;
    logic [7:0] w_sec_nxt, w_min_nxt, w_hr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.mode_btn) begin
            case (r_state)
                RUN:     w_state_nxt = SET_HR;
                SET_HR:  w_state_nxt = SET_MIN;
                SET_MIN: w_state_nxt = SET_SEC;
                SET_SEC: w_state_nxt = RUN;
            endcase
        end
    end

    assign w_edit = bus.up_btn | bus.down_btn;

`ifdef TICK_IN_SET_EN
    assign w_tick_go = bus.tick_1hz & ((r_state == RUN) | ~w_edit);
`else
    assign w_tick_go = bus.tick_1hz & (r_state == RUN);
`endif

    // A tick and an edit never both reach a stepper, so carries only follow ticks.
    assign w_sec_inc = w_tick_go | ((r_state == SET_SEC) & bus.up_btn);
    assign w_sec_dec = (r_state == SET_SEC) & bus.down_btn;
    assign w_min_inc = (w_tick_go & w_sec_wrap) | ((r_state == SET_MIN) & bus.up_btn);
    assign w_min_dec = (r_state == SET_MIN) & bus.down_btn;
    assign w_hr_inc  = (w_tick_go & w_min_wrap) | ((r_state == SET_HR) & bus.up_btn);
    assign w_hr_dec  = (r_state == SET_HR) & bus.down_btn;

    wrap_stepper #(.MOD(SEC_MOD)) u_sec (
        .val (r_sec), .inc (w_sec_inc), .dec (w_sec_dec),
        .nxt (w_sec_nxt), .wrap (w_sec_wrap)
    );

    wrap_stepper #(.MOD(MIN_MOD)) u_min (
        .val (r_min), .inc (w_min_inc), .dec (w_min_dec),
        .nxt (w_min_nxt), .wrap (w_min_wrap)
    );

    wrap_stepper #(.MOD(HOURS_MOD)) u_hr (
        .val (r_hr), .inc (w_hr_inc), .dec (w_hr_dec),
        .nxt (w_hr_nxt), .wrap (w_hr_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hr  <= 8'd0;
            r_min <= 8'd0;
            r_sec <= 8'd0;
            r_day <= 1'b0;
        end else begin
            r_hr  <= w_hr_nxt;
            r_min <= w_min_nxt;
            r_sec <= w_sec_nxt;
            r_day <= w_tick_go & w_hr_wrap;
        end
    end

    assign bus.hr         = r_hr;
    assign bus.min        = r_min;
    assign bus.sec        = r_sec;
    assign bus.day_pulse  = r_day;
    assign bus.edit_field = state_field(r_state);
endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_set_ctrl
//  Description : Scoreboard bench for time_set_ctrl, 24 h and 12 h instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    time_set_ctrl_if ifa ();
    time_set_ctrl_if ifb ();

    time_set_ctrl #(.HOURS_MOD(24)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    time_set_ctrl #(.HOURS_MOD(12)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        int st;
        int h;
        int m;
        int s;
        bit day;
    } mdl_t;

    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
        logic [1:0] ef;
        logic       day;
    } exp_t;

    mdl_t ma, mb;
    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic mdl_t mdl_next(input mdl_t c, input bit tk, input bit md,
                                      input bit up, input bit dn, input int hmod);
        mdl_t n = c;
        bit   tick_ok;
        int   fmod;
        n.day = 1'b0;
`ifdef TICK_IN_SET_EN
        tick_ok = tk && (c.st == 0 || !(up || dn));
`else
        tick_ok = tk && (c.st == 0);
`endif
        if (tick_ok) begin
            n.s = n.s + 1;
            if (n.s == 60) begin
                n.s = 0;
                n.m = n.m + 1;
                if (n.m == 60) begin
                    n.m = 0;
                    n.h = n.h + 1;
                    if (n.h == hmod) begin
                        n.h   = 0;
                        n.day = 1'b1;
                    end
                end
            end
        end
        if (c.st != 0 && up != dn) begin
            fmod = (c.st == 1) ? hmod : 60;
            case (c.st)
                1: n.h = up ? (n.h + 1) % fmod : (n.h + fmod - 1) % fmod;
                2: n.m = up ? (n.m + 1) % fmod : (n.m + fmod - 1) % fmod;
                default: n.s = up ? (n.s + 1) % fmod : (n.s + fmod - 1) % fmod;
            endcase
        end
        if (md) n.st = (c.st + 1) % 4;
        return n;
    endfunction

    function automatic exp_t to_exp(input mdl_t m);
        exp_t e;
        e.hr  = 8'(m.h);
        e.min = 8'(m.m);
        e.sec = 8'(m.s);
        e.ef  = 2'(m.st);
        e.day = m.day;
        return e;
    endfunction

    task automatic drive(input bit tk, input bit md, input bit up, input bit dn);
        ifa.tick_1hz = tk; ifa.mode_btn = md; ifa.up_btn = up; ifa.down_btn = dn;
        ifb.tick_1hz = tk; ifb.mode_btn = md; ifb.up_btn = up; ifb.down_btn = dn;
    endtask

    task automatic compare();
        exp_t e;
        if (qa.size() == 0 || qb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = qa.pop_front();
            chk("A.hr",  32'(ifa.hr),         32'(e.hr));
            chk("A.min", 32'(ifa.min),        32'(e.min));
            chk("A.sec", 32'(ifa.sec),        32'(e.sec));
            chk("A.ef",  32'(ifa.edit_field), 32'(e.ef));
            chk("A.day", 32'(ifa.day_pulse),  32'(e.day));
            e = qb.pop_front();
            chk("B.hr",  32'(ifb.hr),         32'(e.hr));
            chk("B.min", 32'(ifb.min),        32'(e.min));
            chk("B.sec", 32'(ifb.sec),        32'(e.sec));
            chk("B.ef",  32'(ifb.edit_field), 32'(e.ef));
            chk("B.day", 32'(ifb.day_pulse),  32'(e.day));
        end
    endtask

    task automatic step(input bit tk, input bit md, input bit up, input bit dn);
        @(negedge clk);
        drive(tk, md, up, dn);
        ma = mdl_next(ma, tk, md, up, dn, 24);
        mb = mdl_next(mb, tk, md, up, dn, 12);
        qa.push_back(to_exp(ma));
        qb.push_back(to_exp(mb));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        compare();
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hr"},  32'(ifa.hr),  32'(h));
        chk({tag, ".min"}, 32'(ifa.min), 32'(m));
        chk({tag, ".sec"}, 32'(ifa.sec), 32'(s));
    endtask

    task automatic chk_zero(input string tag);
        chk_time(tag, 0, 0, 0);
        chk({tag, ".ef"},  32'(ifa.edit_field), 32'd0);
        chk({tag, ".day"}, 32'(ifa.day_pulse),  32'd0);
        chk({tag, ".Bhr"}, 32'(ifb.hr),         32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};
        qa.delete();
        qb.delete();
    endtask

    // Walks field of model A toward target by the shorter direction.
    task automatic adjust(input int fld, input int target, input int modv);
        int cur, d, n;
        bit up;
        cur = (fld == 1) ? ma.h : (fld == 2) ? ma.m : ma.s;
        d   = (target - cur + modv) % modv;
        up  = (d <= modv / 2);
        n   = up ? d : modv - d;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, up, !up);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        adjust(1, h, 24);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        adjust(2, m, 60);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        adjust(3, s, 60);
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int exp_sec;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        ma = '{default: 0};
        mb = '{default: 0};
        repeat (2) @(posedge clk);
        #1;
        chk_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // Mode sequencing and simultaneous up+down
        step(1'b0, 1'b1, 1'b0, 1'b0);  chk("ef1", 32'(ifa.edit_field), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);  chk("ef2", 32'(ifa.edit_field), 32'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0);  chk("ef3", 32'(ifa.edit_field), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b1);  chk("updn_sec", 32'(ifa.sec), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);  chk("ef0", 32'(ifa.edit_field), 32'd0);

        // Hour down-wrap on both moduli
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hr_dn24", 32'(ifa.hr), 32'd23);
        chk("hr_dn12", 32'(ifb.hr), 32'd11);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("hr_up24", 32'(ifa.hr), 32'd0);
        chk("hr_up12", 32'(ifb.hr), 32'd0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Minute wrap without carry
        set_time(5, 59, 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);  chk_time("min_upwrap", 5, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);  chk_time("min_dnwrap", 5, 59, 0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Day rollover
        set_time(23, 59, 58);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("pre_roll", 23, 59, 59);
        chk("pre_roll.day", 32'(ifa.day_pulse), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("roll", 0, 0, 0);
        chk("roll.day", 32'(ifa.day_pulse), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("roll.day_end", 32'(ifa.day_pulse), 32'd0);

        // Reset mid-count and mid-edit
        set_time(0, 12, 32);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("run_cnt", 0, 12, 34);
        do_reset();
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();

        // Ticks during SET_MIN, then tick coinciding with an edit
        set_time(10, 20, 30);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef TICK_IN_SET_EN
        exp_sec = 35;
`else
        exp_sec = 30;
`endif
        chk_time("set_ticks", 10, 20, exp_sec);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk_time("tick_edit", 10, 21, exp_sec);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_time("tick_mode", 10, 21, exp_sec + 1);
        chk("tick_mode.ef", 32'(ifa.edit_field), 32'd1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Random mixed traffic, checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        chk("sb_drain_a", 32'(qa.size()), 32'd0);
        chk("sb_drain_b", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
